// File: rtl/mem_latency_responder_if.sv
// CPU-side cache request bus for mem_latency_responder: icache and dcache ports plus the shared stall.
interface mem_latency_responder_if;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [3:0]  icache_we;
    logic [31:0] icache_din;
    logic [31:0] instruction;
    logic        stall;

    modport master (
        output dcache_addr, dcache_re, dcache_we, dcache_din,
        output icache_addr, icache_re, icache_we, icache_din,
        input  dcache_dout, instruction, stall
    );

    modport slave (
        input  dcache_addr, dcache_re, dcache_we, dcache_din,
        input  icache_addr, icache_re, icache_we, icache_din,
        output dcache_dout, instruction, stall
    );
endinterface

// File: rtl/mem_latency_responder.sv
// Shared dual-port word RAM behind the icache/dcache ports with a programmable stall window per request.
// Optional feature macro: MEMRESP_LINE_HIT_EN (per-port last-line tag; line hits complete without stalling).
module mem_latency_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int LINE_W  = 2
) (
    input logic clk,
    input logic rst,
    mem_latency_responder_if.slave bus
);
    generate
        if (LATENCY < 0 || LATENCY > 15) begin : gLatencyCheck
            $error("mem_latency_responder: LATENCY must be in 0..15");
        end
        if (LINE_W < 0 || LINE_W >= ADDR_W) begin : gLineCheck
            $error("mem_latency_responder: LINE_W must be in 0..ADDR_W-1");
        end
    endgenerate

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic {IDLE, WAIT} stateT;

    stateT             state, stateNext;
    logic [3:0]        cnt, cntNext;
    logic              stallNext;
    logic              acceptNow, acceptWait, complete;
    logic              dReq, iReq, anyReq, lineHit;
    logic [ADDR_W-1:0] dIdx, iIdx;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       dRdData, iRdData;
    logic              dPend, iPend;
    logic              unusedAddrBits;

    assign dIdx   = bus.dcache_addr[ADDR_W+1:2];
    assign iIdx   = bus.icache_addr[ADDR_W+1:2];
    assign dReq   = bus.dcache_re | (|bus.dcache_we);
    assign iReq   = bus.icache_re | (|bus.icache_we);
    assign anyReq = dReq | iReq;
    assign unusedAddrBits = ^{bus.dcache_addr[31:ADDR_W+2], bus.dcache_addr[1:0],
                              bus.icache_addr[31:ADDR_W+2], bus.icache_addr[1:0]};

`ifdef MEMRESP_LINE_HIT_EN
    localparam int TAG_W = ADDR_W - LINE_W;

    logic [TAG_W-1:0] dTag, iTag, dLine, iLine;
    logic             dValid, iValid;

    assign dLine = bus.dcache_addr[ADDR_W+1:LINE_W+2];
    assign iLine = bus.icache_addr[ADDR_W+1:LINE_W+2];
    // An idle port never forces a miss; any requesting port off its last line does.
    assign lineHit = (!dReq || (dValid && dTag == dLine)) &&
                     (!iReq || (iValid && iTag == iLine));

    always_ff @(posedge clk) begin
        if (rst) begin
            dValid <= 1'b0;
            iValid <= 1'b0;
            dTag   <= '0;
            iTag   <= '0;
        end else if (state == IDLE && anyReq && !lineHit) begin
            if (dReq) begin
                dValid <= 1'b1;
                dTag   <= dLine;
            end
            if (iReq) begin
                iValid <= 1'b1;
                iTag   <= iLine;
            end
        end
    end
`else
    assign lineHit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            bus.stall <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            bus.stall <= stallNext;
        end
    end

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        stallNext  = 1'b0;
        acceptNow  = 1'b0;
        acceptWait = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    acceptNow = 1'b1;
                    if (LATENCY != 0 && !lineHit) begin
                        acceptWait = 1'b1;
                        stateNext  = WAIT;
                        cntNext    = CNT_LOAD;
                        stallNext  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    stateNext = IDLE;
                    complete  = 1'b1;
                end else begin
                    cntNext   = cnt - 4'd1;
                    stallNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Read data is captured at acceptance so a same-edge write is never visible to the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dcache_dout <= '0;
            bus.instruction <= '0;
            dRdData         <= '0;
            iRdData         <= '0;
            dPend           <= 1'b0;
            iPend           <= 1'b0;
        end else begin
            if (acceptWait) begin
                dPend   <= bus.dcache_re;
                iPend   <= bus.icache_re;
                dRdData <= mem[dIdx];
                iRdData <= mem[iIdx];
            end else if (acceptNow) begin
                if (bus.dcache_re) bus.dcache_dout <= mem[dIdx];
                if (bus.icache_re) bus.instruction <= mem[iIdx];
            end
            if (complete) begin
                if (dPend) bus.dcache_dout <= dRdData;
                if (iPend) bus.instruction <= iRdData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && acceptNow) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.icache_we[b] && !(bus.dcache_we[b] && dIdx == iIdx))
                    mem[iIdx][8*b +: 8] <= bus.icache_din[8*b +: 8];
                if (bus.dcache_we[b])
                    mem[dIdx][8*b +: 8] <= bus.dcache_din[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_latency_responder.sv
// Self-checking bench for mem_latency_responder: four instances at LATENCY 0/3/5/4 driven from a
// vector table and hand sequences, with expected outputs queued at drive time and checked at completion.
module tb_mem_latency_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] dAddr [4];
    logic [31:0] dDin  [4];
    logic [31:0] iAddr [4];
    logic [31:0] iDin  [4];
    logic        dRe   [4];
    logic        iRe   [4];
    logic [3:0]  dWe   [4];
    logic [3:0]  iWe   [4];
    logic        rstV  [4];
    wire         stallObs [4];
    wire  [31:0] doutObs  [4];
    wire  [31:0] instrObs [4];

    for (genvar g = 0; g < 4; g++) begin : gDut
        mem_latency_responder_if bus ();
        assign bus.dcache_addr = dAddr[g];
        assign bus.dcache_re   = dRe[g];
        assign bus.dcache_we   = dWe[g];
        assign bus.dcache_din  = dDin[g];
        assign bus.icache_addr = iAddr[g];
        assign bus.icache_re   = iRe[g];
        assign bus.icache_we   = iWe[g];
        assign bus.icache_din  = iDin[g];
        assign stallObs[g]     = bus.stall;
        assign doutObs[g]      = bus.dcache_dout;
        assign instrObs[g]     = bus.instruction;

        mem_latency_responder #(
            .ADDR_W (10),
            .LATENCY(g == 0 ? 0 : g == 1 ? 3 : g == 2 ? 5 : 4),
            .LINE_W (2)
        ) dut (
            .clk(clk),
            .rst(rstV[g]),
            .bus(bus)
        );
    end

`ifdef MEMRESP_LINE_HIT_EN
    localparam bit HIT = 1'b1;
`else
    localparam bit HIT = 1'b0;
`endif

    typedef struct {
        logic [31:0] dA;
        logic        dR;
        logic [3:0]  dW;
        logic [31:0] dD;
        logic [31:0] iA;
        logic        iR;
        logic [3:0]  iW;
        logic [31:0] iD;
        logic [31:0] expD;
        logic [31:0] expI;
    } vecT;

    typedef struct {
        int          k;
        int          id;
        int          stallExp;
        logic [31:0] expD;
        logic [31:0] expI;
    } expT;

    expT sb[$];
    vecT vecs[12];
    vecT v;
    int  assertCount = 0;
    int  failCount   = 0;

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkOutput();
        expT e;
        int  n;
        if (sb.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        n = 0;
        @(negedge clk);
        while (stallObs[e.k] === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkValue($sformatf("dut%0d step%0d stall cycles", e.k, e.id), 32'(n), 32'(e.stallExp));
        checkValue($sformatf("dut%0d step%0d dcache_dout", e.k, e.id), doutObs[e.k], e.expD);
        checkValue($sformatf("dut%0d step%0d instruction", e.k, e.id), instrObs[e.k], e.expI);
    endtask

    task automatic applyStimulus(input int k, input vecT s, input int stallExp, input int id);
        sb.push_back('{k, id, stallExp, s.expD, s.expI});
        @(negedge clk);
        dAddr[k] = s.dA; dRe[k] = s.dR; dWe[k] = s.dW; dDin[k] = s.dD;
        iAddr[k] = s.iA; iRe[k] = s.iR; iWe[k] = s.iW; iDin[k] = s.iD;
        @(posedge clk);
        #1;
        dRe[k] = 1'b0; dWe[k] = 4'h0; iRe[k] = 1'b0; iWe[k] = 4'h0;
        checkOutput();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            dAddr[k] = '0; dDin[k] = '0; iAddr[k] = '0; iDin[k] = '0;
            dRe[k] = 1'b0; iRe[k] = 1'b0; dWe[k] = 4'h0; iWe[k] = 4'h0;
            rstV[k] = 1'b1;
        end

        // LATENCY=0 table: byte masks, shared RAM, dual-write merge, read-first, address boundaries.
        vecs[0]  = '{32'h10000010, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{32'h10000010, 1'b1, 4'h0, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2]  = '{32'h0,        1'b0, 4'h0, 32'h0,        32'h20,       1'b0, 4'hF, 32'h11223344, 32'hDEADBEEF, 32'h0};
        vecs[3]  = '{32'h20,       1'b0, 4'h2, 32'h0000AA00, 32'h0,        1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[4]  = '{32'h0,        1'b0, 4'h0, 32'h0,        32'h20,       1'b1, 4'h0, 32'h0,        32'hDEADBEEF, 32'h1122AA44};
        vecs[5]  = '{32'h20,       1'b1, 4'h0, 32'h0,        32'h10,       1'b1, 4'h0, 32'h0,        32'h1122AA44, 32'hDEADBEEF};
        vecs[6]  = '{32'h40,       1'b0, 4'hF, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h1122AA44, 32'hDEADBEEF};
        vecs[7]  = '{32'h40,       1'b0, 4'h3, 32'hAAAAAAAA, 32'h40,       1'b0, 4'h6, 32'hBBBBBBBB, 32'h1122AA44, 32'hDEADBEEF};
        vecs[8]  = '{32'h40,       1'b1, 4'h0, 32'h0,        32'h40,       1'b0, 4'hF, 32'h12345678, 32'h00BBAAAA, 32'hDEADBEEF};
        vecs[9]  = '{32'hFFC,      1'b0, 4'hF, 32'hA5A5A5A5, 32'h40,       1'b1, 4'h0, 32'h0,        32'h00BBAAAA, 32'h12345678};
        vecs[10] = '{32'hFFC,      1'b1, 4'h0, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'hA5A5A5A5, 32'h12345678};
        vecs[11] = '{32'h0,        1'b0, 4'h0, 32'h0,        32'hFFFFFFFC, 1'b1, 4'h0, 32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checkValue($sformatf("dut%0d reset stall", k), {31'b0, stallObs[k]}, 32'h0);
            checkValue($sformatf("dut%0d reset dcache_dout", k), doutObs[k], 32'h0);
            checkValue($sformatf("dut%0d reset instruction", k), instrObs[k], 32'h0);
            rstV[k] = 1'b0;
        end

        for (int i = 0; i < 12; i++) applyStimulus(0, vecs[i], 0, i);

        // LATENCY=3: stall window, same-edge read-first across ports.
        v = '{32'h100, 1'b0, 4'hF, 32'h12345678, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0};
        applyStimulus(1, v, 3, 100);
        v = '{32'h100, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h12345678, 32'h0};
        applyStimulus(1, v, HIT ? 0 : 3, 101);
        v = '{32'h200, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h12345678, 32'h0};
        applyStimulus(1, v, 3, 102);
        v = '{32'h200, 1'b0, 4'hF, 32'hCAFEF00D, 32'h200, 1'b1, 4'h0, 32'h0, 32'h12345678, 32'h0};
        applyStimulus(1, v, 3, 103);
        v = '{32'h0, 1'b0, 4'h0, 32'h0, 32'h200, 1'b1, 4'h0, 32'h0, 32'h12345678, 32'hCAFEF00D};
        applyStimulus(1, v, HIT ? 0 : 3, 104);

        // LATENCY=5: reset in the second WAIT cycle drops the pending read but keeps RAM.
        v = '{32'h300, 1'b0, 4'hF, 32'h55AA55AA, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0};
        applyStimulus(2, v, 5, 200);
        v = '{32'h300, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h55AA55AA, 32'h0};
        applyStimulus(2, v, HIT ? 0 : 5, 201);
        @(negedge clk);
        iAddr[2] = 32'h300;
        iRe[2]   = 1'b1;
        @(posedge clk);
        #1;
        iRe[2] = 1'b0;
        @(negedge clk);
        checkValue("dut2 first WAIT cycle stall", {31'b0, stallObs[2]}, 32'h1);
        checkValue("dut2 dcache_dout held in WAIT", doutObs[2], 32'h55AA55AA);
        @(negedge clk);
        checkValue("dut2 second WAIT cycle stall", {31'b0, stallObs[2]}, 32'h1);
        rstV[2] = 1'b1;
        @(negedge clk);
        checkValue("dut2 stall after mid-WAIT reset", {31'b0, stallObs[2]}, 32'h0);
        checkValue("dut2 dcache_dout after mid-WAIT reset", doutObs[2], 32'h0);
        checkValue("dut2 instruction after mid-WAIT reset", instrObs[2], 32'h0);
        rstV[2] = 1'b0;
        v = '{32'h300, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h55AA55AA, 32'h0};
        applyStimulus(2, v, 5, 202);

        // LATENCY=4: same-line accesses are free only when line tracking is built in.
        v = '{32'h100, 1'b0, 4'hF, 32'h000000A0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0};
        applyStimulus(3, v, 4, 300);
        v = '{32'h104, 1'b0, 4'hF, 32'h000000A1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0};
        applyStimulus(3, v, HIT ? 0 : 4, 301);
        v = '{32'h110, 1'b0, 4'hF, 32'h000000A2, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0};
        applyStimulus(3, v, 4, 302);
        v = '{32'h100, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h000000A0, 32'h0};
        applyStimulus(3, v, 4, 303);
        v = '{32'h104, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h000000A1, 32'h0};
        applyStimulus(3, v, HIT ? 0 : 4, 304);
        v = '{32'h110, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h000000A2, 32'h0};
        applyStimulus(3, v, 4, 305);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
